// File: rtl/fp_cvt96_to16_pipe.sv
// fp_cvt96_to16_pipe: 3-stage FP96 -> FP16 narrowing converter with
// rounding, overflow, underflow and NaN handling, valid/ready stallable.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/i/rm operand
// side; out_valid/out_ready/o/flags result side,
// flags = {invalid, overflow, underflow, inexact}.
// Optional macro FPCVT96TO16_FTZ_EN: flush subnormal results to zero.
module fp_cvt96_to16_pipe #(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] i,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] o,
    output logic [3:0]  flags
);

    if (STAGES != 3) begin : g_bad_stages
        $error("fp_cvt96_to16_pipe: only STAGES == 3 is supported");
    end

    typedef enum logic [2:0] {
        CL_FIN,
        CL_ZERO,
        CL_TINY,
        CL_INF,
        CL_NAN
    } cls_e;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic w_adv;
    logic r_v1, r_v2, r_v3;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;

    // ---------------- S1: classify ----------------
    logic [14:0]        w_exp;
    logic [79:0]        w_sig;
    logic signed [16:0] w_e;
    cls_e               w_cls;

    assign w_exp = i[94:80];
    assign w_sig = i[79:0];
    // exp - 0x3FFF + 0x0F folded into one constant
    assign w_e   = $signed({2'b00, w_exp} - 17'd16368);

    always_comb begin
        w_cls = CL_FIN;
        unique case (1'b1)
            (w_exp == 15'h0000): w_cls = (w_sig == '0) ? CL_ZERO : CL_TINY;
            (w_exp == 15'h7FFF): w_cls = (w_sig == '0) ? CL_INF : CL_NAN;
            default:             w_cls = CL_FIN;
        endcase
    end

    logic               r1_sign;
    logic [2:0]         r1_rm;
    cls_e               r1_cls;
    logic signed [16:0] r1_e;
    logic [80:0]        r1_m;

    // ---------------- S2: align ----------------
    // Subnormal right shift by (1-e) is done as a shift of {m,10'b0}
    // by -e, so the fraction lands in bits [90:81].
    logic [16:0] w_shm;
    logic [90:0] w_shr;
    logic [9:0]  w_frac;
    logic        w_grd;
    logic        w_stk;
    logic        w_tiny;
    logic        w_ovf_e;
    logic [4:0]  w_expf;

    assign w_shm = 17'd0 - r1_e;
    assign w_shr = {r1_m, 10'b0} >> w_shm[3:0];

    always_comb begin
        w_frac  = '0;
        w_grd   = 1'b0;
        w_stk   = 1'b0;
        w_tiny  = 1'b0;
        w_ovf_e = 1'b0;
        w_expf  = '0;
        unique case (r1_cls)
            CL_NAN: w_frac = r1_m[79:70];
            CL_TINY: begin
                // below the smallest subnormal: only sticky survives
                w_stk  = 1'b1;
                w_tiny = 1'b1;
            end
            CL_FIN: begin
                if (r1_e > 17'sd0) begin
                    w_frac  = r1_m[79:70];
                    w_grd   = r1_m[69];
                    w_stk   = |r1_m[68:0];
                    w_expf  = r1_e[4:0];
                    w_ovf_e = (r1_e >= 17'sd31);
                end else begin
                    w_tiny = 1'b1;
                    if (w_shm >= 17'd11) begin
                        w_stk = |r1_m;
                    end else begin
                        w_frac = w_shr[90:81];
                        w_grd  = w_shr[80];
                        w_stk  = |w_shr[79:0];
                    end
                end
            end
            default: ;
        endcase
    end

    logic       r2_sign;
    logic [2:0] r2_rm;
    cls_e       r2_cls;
    logic [9:0] r2_frac;
    logic       r2_grd;
    logic       r2_stk;
    logic       r2_tiny;
    logic       r2_ovf_e;
    logic [4:0] r2_expf;

    // ---------------- S3: round / pack ----------------
    logic        w_nx;
    logic        w_inc;
    logic        w_big_inf;
    logic [14:0] w_pack;
    logic        w_ovf;
    logic [15:0] w_o;
    logic [3:0]  w_f;

    assign w_nx = r2_grd || r2_stk;

    always_comb begin
        w_inc     = r2_grd && (r2_stk || r2_frac[0]);
        w_big_inf = 1'b1;
        unique case (r2_rm)
            RM_RTZ: begin
                w_inc     = 1'b0;
                w_big_inf = 1'b0;
            end
            RM_RDN: begin
                w_inc     = r2_sign && w_nx;
                w_big_inf = r2_sign;
            end
            RM_RUP: begin
                w_inc     = !r2_sign && w_nx;
                w_big_inf = !r2_sign;
            end
            RM_RMM: w_inc = r2_grd;
            default: ;
        endcase
    end

    // carry out of the fraction ripples into the exponent field,
    // which also turns a 0x3FF subnormal round-up into the min normal
    assign w_pack = {r2_expf, r2_frac} + {14'd0, w_inc};
    assign w_ovf  = r2_ovf_e || (w_pack[14:10] == 5'h1F);

    always_comb begin
        w_o = {r2_sign, 15'h0000};
        w_f = 4'h0;
        unique case (r2_cls)
            CL_ZERO: ;
            CL_INF:  w_o = {r2_sign, 15'h7C00};
            CL_NAN: begin
                w_o = {r2_sign, 5'h1F, 1'b1, r2_frac[8:0]};
                w_f = {!r2_frac[9], 3'b000};
            end
            default: begin
                if (w_ovf) begin
                    w_o = {r2_sign, w_big_inf ? 15'h7C00 : 15'h7BFF};
                    w_f = 4'b0101;
                end else begin
`ifdef FPCVT96TO16_FTZ_EN
                    if (w_pack[14:10] == 5'h00) begin
                        w_o = {r2_sign, 15'h0000};
                        w_f = 4'b0011;
                    end else begin
                        w_o = {r2_sign, w_pack};
                        w_f = {2'b00, r2_tiny && w_nx, w_nx};
                    end
`else
                    w_o = {r2_sign, w_pack};
                    w_f = {2'b00, r2_tiny && w_nx, w_nx};
`endif
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            o     <= 16'h0000;
            flags <= 4'h0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_v2) begin
                o     <= w_o;
                flags <= w_f;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (in_valid) begin
                r1_sign <= i[95];
                r1_rm   <= rm;
                r1_cls  <= w_cls;
                r1_e    <= w_e;
                r1_m    <= {1'b1, w_sig};
            end
            if (r_v1) begin
                r2_sign  <= r1_sign;
                r2_rm    <= r1_rm;
                r2_cls   <= r1_cls;
                r2_frac  <= w_frac;
                r2_grd   <= w_grd;
                r2_stk   <= w_stk;
                r2_tiny  <= w_tiny;
                r2_ovf_e <= w_ovf_e;
                r2_expf  <= w_expf;
            end
        end
    end

    assign out_valid = r_v3;

endmodule

// File: tb/tb_fp_cvt96_to16_pipe.sv
// tb_fp_cvt96_to16_pipe: table-driven vectors with a scoreboard queue,
// plus latency, stall-stream and mid-stream reset sequences.
module tb_fp_cvt96_to16_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] i = '0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_cvt96_to16_pipe #(.STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .i(i), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .flags(flags)
    );

`ifdef FPCVT96TO16_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    localparam logic [79:0] B69  = 80'd1 << 69;
    localparam logic [79:0] B70  = 80'd1 << 70;
    localparam logic [79:0] TOP10 = 80'hFFC00000000000000000;
    localparam logic [79:0] TOP11 = 80'hFFE00000000000000000;

    typedef struct {
        logic [95:0] x;
        logic [2:0]  r;
        logic [15:0] eo;
        logic [3:0]  ef;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] sbq[$];
    logic [15:0] ex_o = '0;
    logic [3:0]  ex_f = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          tog_en = 1'b0;
    int          tcnt = 0;

    function automatic logic [95:0] f96(input logic s, input logic [14:0] e,
                                        input logic [79:0] m);
        return {s, e, m};
    endfunction

    task automatic add(input logic [95:0] x, input logic [2:0] r,
                       input logic [15:0] eo, input logic [3:0] ef);
        vec_t v;
        v.x = x; v.r = r; v.eo = eo; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int n;
        i = v.x; rm = v.r; ex_o = v.eo; ex_f = v.ef; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    // scoreboard: expected pushed on accept, compared every valid cycle
    // (so a stalled result must stay put), popped on transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stale_output: got o=%h flags=%h, required no output",
                             o, flags);
                end else begin
                    chk("result", {12'd0, o, flags}, {12'd0, sbq[0]});
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            if (in_valid && in_ready) sbq.push_back({ex_o, ex_f});
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            out_ready = (tcnt % 3 == 0);
            tcnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        add(f96(0, 15'h3FFF, 80'h0), 0, 16'h3C00, 4'h0);
        add(f96(0, 15'h3FFF, B69), 0, 16'h3C00, 4'h1);
        add(f96(0, 15'h3FFF, B69), 3, 16'h3C01, 4'h1);
        add(f96(0, 15'h3FFF, B69), 1, 16'h3C00, 4'h1);
        add(f96(0, 15'h400F, 80'h0), 0, 16'h7C00, 4'h5);
        add(f96(0, 15'h400F, 80'h0), 1, 16'h7BFF, 4'h5);
        add(f96(1, 15'h400F, 80'h0), 3, 16'hFBFF, 4'h5);
        add(f96(0, 15'h400F, 80'h0), 2, 16'h7BFF, 4'h5);
        add(f96(1, 15'h400F, 80'h0), 2, 16'hFC00, 4'h5);
        add(f96(1, 15'h400F, 80'h0), 4, 16'hFC00, 4'h5);
        add(f96(0, 15'h3FE7, 80'h0), 0, FTZ ? 16'h0000 : 16'h0001,
            FTZ ? 4'h3 : 4'h0);
        add(f96(0, 15'h3FE6, 80'h0), 0, 16'h0000, 4'h3);
        add(f96(0, 15'h3FE6, 80'h0), 3, FTZ ? 16'h0000 : 16'h0001, 4'h3);
        add(f96(1, 15'h3FE6, 80'h0), 2, FTZ ? 16'h8000 : 16'h8001, 4'h3);
        add(f96(0, 15'h7FFF, 80'h1), 0, 16'h7E00, 4'h8);
        add(f96(0, 15'h7FFF, TOP10), 0, 16'h7FFF, 4'h0);
        add(f96(1, 15'h7FFF, 80'h0), 0, 16'hFC00, 4'h0);
        add(f96(1, 15'h0000, 80'h0), 0, 16'h8000, 4'h0);
        add(f96(0, 15'h3FFF, B69 | B70), 0, 16'h3C02, 4'h1);
        add(f96(0, 15'h3FFF, B69), 4, 16'h3C01, 4'h1);
        add(f96(1, 15'h3FFF, B69), 2, 16'hBC01, 4'h1);
        add(f96(0, 15'h3FFF, B69), 7, 16'h3C00, 4'h1);
        add(f96(0, 15'h3FFF, B69 | B70), 5, 16'h3C02, 4'h1);
        add(f96(0, 15'h400E, TOP11), 0, 16'h7C00, 4'h5);
        add(f96(0, 15'h400E, TOP11), 1, 16'h7BFF, 4'h1);
        add(f96(0, 15'h3FF0, TOP10), 0, 16'h0400, 4'h3);
        add(f96(0, 15'h3FF1, 80'h0), 0, 16'h0400, 4'h0);
        add(f96(0, 15'h0000, 80'h1), 3, FTZ ? 16'h0000 : 16'h0001, 4'h3);
        add(f96(0, 15'h0000, 80'h1), 0, 16'h0000, 4'h3);
        add(f96(0, 15'h3F00, 80'h0), 3, FTZ ? 16'h0000 : 16'h0001, 4'h3);

        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_o", {16'd0, o}, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        @(posedge clk); #1;

        // latency of a single op
        send(vecs[0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", n, 3);
        drain();
        @(posedge clk); #1;

        // full table, back to back
        for (int k = 0; k < vecs.size(); k++) send(vecs[k]);
        drain();
        @(posedge clk); #1;

        // stream of 8 with out_ready 1,0,0,1,...
        tcnt = 0;
        tog_en = 1'b1;
        for (int k = 0; k < 8; k++) send(vecs[(k * 3) % vecs.size()]);
        drain();

        // same stream with reset asserted mid-way
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
                chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
                @(posedge clk); #1;
            end
            send(vecs[(k * 5 + 1) % vecs.size()]);
        end
        drain();
        tog_en = 1'b0;
        #2 out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cvt96_to16_pipe.md
Name: fp_cvt96_to16_pipe

Overview:
Pipelined narrowing converter from FP96 (sign, 15-bit exp, 80-bit fraction, bias 0x3FFF) to FP16 (sign, 5-bit exp, 10-bit fraction, bias 0x0F). It is the inverse path of the FP16-to-FP96 widening converter and sits on the FPU result/store path, where triple-precision values are written back as half precision.
- Adds rounding, overflow, underflow and NaN handling.
- Uses a valid/ready handshake, so it can be stalled by the writeback stage.

Parameters:
- STAGES, 3, fixed pipeline depth; only 3 is supported and any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  input operand valid
- in_ready  out  1  converter accepts input this cycle
- i  in  96  FP96 operand {sign, exp[14:0], sig[79:0]}
- rm  in  3  rounding mode, sampled with i: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 behave as RNE
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- o  out  16  FP16 result {sign, exp[4:0], sig[9:0]}
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with o

Behaviour:
- Reset (rst_n==0 at clk edge):
  - all stage valids clear; out_valid=0, o=16'h0, flags=4'h0.
  - In-flight operands are discarded; there is no partial completion.
  - in_ready=1 in the first cycle after reset is released.
- Handshake:
  - transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
  - in_ready = !s3_valid || out_ready. This is a global stall: when it is 0, all stages hold.
  - o/flags stay stable while out_valid&&!out_ready.
- Latency is 3 cycles and throughput is 1/cycle with out_ready held high.
- S1 (classify):
  - Compute e = i.exp - 0x3FFF + 0x0F as a signed 17-bit value.
  - Classes: zero (exp==0, sig==0), tiny96 (exp==0, sig!=0), inf (exp==0x7FFF, sig==0), nan (exp==0x7FFF, sig!=0), finite.
  - Register sign, rm, class, e, and m = {1'b1, sig}.
- S2 (align):
  - Normal, e>=1: frac=sig[79:70], guard=sig[69], sticky=|sig[68:0].
  - Subnormal, e<=0: shift m right by 1-e. Shifts >=12 give frac=0, guard=0 and sticky=|m (the shift count is clamped).
  - tiny96: treated as a nonzero value below the smallest subnormal (frac=0, guard=0, sticky=1).
- S3 (round/pack):
  - Increment rule:
    - RNE: guard&&(sticky||lsb).
    - RTZ: never.
    - RDN: sign&&(guard||sticky).
    - RUP: !sign&&(guard||sticky).
    - RMM: guard.
  - A fraction carry-out increments the exponent. A subnormal rounding to 0x400 becomes the smallest normal.
  - inexact = guard||sticky.
  - underflow = result tiny before rounding && inexact.
- Overflow (e>=31, or rounding carries exp to 31): overflow=1, inexact=1.
  - RNE/RMM give inf.
  - RTZ gives max finite 0x7BFF with sign.
  - RDN gives +0x7BFF / -inf.
  - RUP gives +inf / -0x7BFF.
- Specials:
  - zero gives signed zero, no flags.
  - inf gives signed 0x7C00, no flags.
  - NaN gives {sign, 5'h1F, 1'b1, sig[78:70]}, i.e. quieted with payload kept; invalid=1 iff sig[79]==0 (signalling).
- Flags are zero for exact finite results.

Optional Feature:
- FPCVT96TO16_FTZ_EN
- Defined: any result that would be subnormal or zero-after-rounding from a nonzero input is flushed to signed zero in S3, with underflow=1 and inexact=1, regardless of rm. Exact subnormals are also flushed (flags set).
- Undefined: gradual underflow exactly as above.

Test Plan:
- 1.0 (sign0, exp 0x3FFF, sig 0), rm=RNE -> o=0x3C00, flags=0, out_valid exactly 3 cycles after accept.
- 1+2^-11 (exp 0x3FFF, sig[69]=1 only) -> RNE 0x3C00, RUP 0x3C01, RTZ 0x3C00; inexact=1 in all three.
- 2^16 (exp 0x400F) -> RNE 0x7C00 with overflow+inexact; RTZ 0x7BFF; same value negative under RUP -> 0xFBFF.
- 2^-24 (exp 0x3FE7) -> 0x0001, flags=0; 2^-25 (exp 0x3FE6) with RNE -> 0x0000 and underflow+inexact; with RUP -> 0x0001. Under FTZ, both inputs -> 0x0000 with UF+NX.
- sNaN (exp 0x7FFF, sig=80'h1) -> 0x7E00 with invalid=1; qNaN with sig[79:70]=10'h3FF -> 0x7FFF with flags=0; -inf -> 0xFC00.
- Back-to-back stream of 8 ops with out_ready toggled 1,0,0,1,...:
  - no loss or duplication, results in order, o stable while stalled.
  - Assert rst_n=0 mid-stream -> out_valid=0 next cycle and no stale result afterwards.
